// File: rtl/fpdiv_arbiter_if.sv
// Request / fpdiv / response bundle of the two-requester fpdiv arbiter.
// slave  : the arbiter's view (accepts requests, drives the fpdiv, returns responses).
// master : the environment's view (requesters, fpdiv, response consumer).
interface fpdiv_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_n;
    logic [31:0] req0_d;
    logic [1:0]  req0_rm;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_n;
    logic [31:0] req1_d;
    logic [1:0]  req1_rm;

    logic [31:0] div_n;
    logic [31:0] div_d;
    logic [1:0]  div_rm;
    logic [31:0] div_q;

    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [31:0] resp_q;

    modport slave (
        input  req0_valid, req0_n, req0_d, req0_rm,
        output req0_ready,
        input  req1_valid, req1_n, req1_d, req1_rm,
        output req1_ready,
        output div_n, div_d, div_rm,
        input  div_q,
        output resp_valid, resp_id, resp_q,
        input  resp_ready
    );

    modport master (
        output req0_valid, req0_n, req0_d, req0_rm,
        input  req0_ready,
        output req1_valid, req1_n, req1_d, req1_rm,
        input  req1_ready,
        input  div_n, div_d, div_rm,
        output div_q,
        input  resp_valid, resp_id, resp_q,
        output resp_ready
    );
endinterface

// File: rtl/fpdiv_arbiter.sv
// Two-requester round-robin arbiter in front of a single fixed-latency fpdiv.
// One operation outstanding at most: IDLE -> RUN (LATENCY edges) -> HOLD (until
// the response is taken) -> IDLE. LATENCY must lie in 1..255.
// Optional macro FPDIV_ARB_STATS_EN adds saturating per-requester completion
// counters stat_done0 / stat_done1.
module fpdiv_arbiter #(
    parameter int unsigned LATENCY = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    fpdiv_arbiter_if.slave       bus,
    output logic                 busy
`ifdef FPDIV_ARB_STATS_EN
    ,
    output logic [15:0]          stat_done0,
    output logic [15:0]          stat_done1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  cnt_q;
    logic        rr_q;       // id of the requester granted last
    logic        grant_any;
    logic        grant_id;
    logic        resp_hs;

    // Grant selection: a lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        grant_any = bus.req0_valid | bus.req1_valid;
        grant_id  = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~rr_q;
        end else if (bus.req1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign resp_hs = (state_q == HOLD) && bus.resp_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; HOLD always leaves to IDLE so a new grant waits one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (grant_any)       state_d = RUN;
            RUN:  if (cnt_q == '0)     state_d = HOLD;
            HOLD: if (bus.resp_ready)  state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    // Outputs decoded from state: handshake readies and busy.
    always_comb begin
        busy           = (state_q != IDLE);
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        if ((state_q == IDLE) && !reset) begin
            bus.req0_ready = bus.req0_valid && (grant_id == 1'b0);
            bus.req1_ready = bus.req1_valid && (grant_id == 1'b1);
        end
    end

    // Operand latch, latency counter, round-robin pointer and response capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.div_n      <= '0;
            bus.div_d      <= '0;
            bus.div_rm     <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_id    <= 1'b0;
            bus.resp_q     <= '0;
            cnt_q          <= '0;
            rr_q           <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        bus.div_n   <= grant_id ? bus.req1_n  : bus.req0_n;
                        bus.div_d   <= grant_id ? bus.req1_d  : bus.req0_d;
                        bus.div_rm  <= grant_id ? bus.req1_rm : bus.req0_rm;
                        bus.resp_id <= grant_id;
                        rr_q        <= grant_id;
                        cnt_q       <= CNT_LOAD;
                    end
                end
                RUN: begin
                    if (cnt_q == '0) begin
                        bus.resp_q     <= bus.div_q;
                        bus.resp_valid <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                HOLD: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                    end
                end
                default: begin
                    bus.resp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FPDIV_ARB_STATS_EN
    // Saturating completion counters, bumped on each response handshake by owner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_done0 <= '0;
            stat_done1 <= '0;
        end else if (resp_hs) begin
            if (!bus.resp_id && (stat_done0 != '1)) stat_done0 <= stat_done0 + 16'd1;
            if ( bus.resp_id && (stat_done1 != '1)) stat_done1 <= stat_done1 + 16'd1;
        end
    end
`else
    logic unused_resp_hs;
    assign unused_resp_hs = resp_hs;
`endif

endmodule
